attack_mask_scan: RTL
=====================

// Module: attack_mask_scan
// PURPOSE
//  Sequential, parametrised successor to the single-square attack test. Latches one board and scans all 64
//  squares, LANES squares per cycle, for attacks by a runtime-selected side. Emits a 64-bit attack mask with a
//  one-cycle valid pulse. Feeds move legality (castling through check, king moves) and evaluation in the search core.
// PARAMETERS
//  PIECE_WIDTH  4    bits per square code; piece codes come from the shared defines (`EMPTY_POSN, `WHITE_*, `BLACK_*)
//  ROW_WIDTH    32   8*PIECE_WIDTH
//  BOARD_WIDTH  256  64*PIECE_WIDTH; square s = rank*8+file holds board[s*PIECE_WIDTH +: PIECE_WIDTH]
//  LANES        8    squares evaluated per cycle; legal values 1,2,4,8,16,32,64 (elaboration $error otherwise)
// PORTS
//  clk             in   1            clock
//  reset           in   1            synchronous, active-high
//  board           in   BOARD_WIDTH  position to scan
//  attacker        in   1            `WHITE_ATTACK / `BLACK_ATTACK side whose attacks are computed
//  board_valid     in   1            request; accepted only when board_ready=1
//  board_ready     out  1            high in IDLE
//  attack_mask     out  64           bit s = square s attacked by attacker
//  attack_valid    out  1            one-cycle pulse, attack_mask stable from then until next accept
//  in_check        out  1            (ATTACK_SCAN_CHECK_EN only) defender king square attacked
// BEHAVIOUR
//  - Reset: state=IDLE, board_ready=1, attack_mask=0, attack_valid=0, in_check=0, scan counter=0; reset mid-scan aborts, no pulse.
//  - IDLE: board_valid&&board_ready -> latch board+attacker, clear mask, counter=0, go SCAN. board_valid outside IDLE is ignored (not queued).
//  - SCAN: each cycle lanes l=0..LANES-1 evaluate square counter*LANES+l from the latched board and write mask bits;
//    counter increments; after 64/LANES cycles go DONE. Input board may change freely during SCAN.
//  - DONE: attack_valid=1 for exactly one cycle, then IDLE. board_ready=0 in SCAN and DONE.
//  - Latency: accept edge to attack_valid = 64/LANES + 1 cycles (LANES=8 -> 9). Throughput: one board per 64/LANES+2 cycles.
//  - Attack rules per target square (r,f), attacker pieces only:
//    knight: 8 L offsets, off-board discarded (no file wrap a<->h); king: 8 neighbours;
//    white pawn attacks from (r-1,f+-1), black pawn from (r+1,f+-1);
//    rook/queen along 4 orthogonal rays, bishop/queen along 4 diagonal rays; ray walks out from target,
//    stops at first non-`EMPTY_POSN square; attacked if that piece is a matching slider of attacker colour.
//  - Target square's own occupant is irrelevant (occupied squares can be attacked; a piece never attacks itself).
//  - Edge squares: rays of length 0 produce no attack; rank/file math must never alias across board edges.
// CONFIGURATION
//  ATTACK_SCAN_CHECK_EN defined: during SCAN, record the square of the defender's king (lowest index if several);
//    in DONE in_check = attack_mask[king_sq]; no defender king -> in_check=0. in_check updates with attack_valid.
//  Not defined: in_check port absent, no king tracking logic.
// STRUCTURE
//  - Shared package attack_pkg: scan_state_t enum {IDLE,SCAN,DONE}, knight/king offset tables, ray direction
//    table (dr,df), function sq_on_board(r,f). Piece/colour codes stay in the existing shared defines.
//  - One sub-module: attack_square_eval (combinational; inputs latched board, attacker, 6-bit square; output attacked);
//    instantiated LANES times by generate. Parent holds FSM, counter, mask register, optional king tracker.
// TESTING
//  1 Empty board + white king e1 only, attacker=white -> mask = d1,d2,e2,f2,f1 only; valid 9 cycles after accept (LANES=8).
//  2 White rook a1, black pawn a4, attacker=white -> a2,a3,a4,b1..h1 set; a5..a8 clear (ray blocked).
//  3 White knight h1 -> only f2,g3 set; no wrap to a-file squares. Black pawn d5, attacker=black -> only c4,e4.
//  4 Start position, attacker=black -> mask = ranks 6-7 fully set plus b8,c8,d8,e8,f8,g8 (a8,h8 clear), ranks 1-5 clear; with CHECK_EN in_check=0.
//  5 CHECK_EN: white king e1, black queen e8, empty between, attacker=black -> in_check=1; add white pawn e2 -> in_check=0.
//  6 Reset asserted mid-SCAN -> no attack_valid, mask=0, board_ready=1 next cycle; board_valid held in SCAN ignored;
//    repeat test 1 with LANES=1 (latency 65) and LANES=64 (latency 2), identical masks.

Source files
------------

// File: rtl/attack_pkg.sv
// Shared scan-state type and board geometry tables for the attack scanner.
// Supplies the piece/colour code defines when the shared defines have not already been seen.
`ifndef EMPTY_POSN
`define EMPTY_POSN    4'd0
`define WHITE_PAWN    4'd1
`define WHITE_KNIGHT  4'd2
`define WHITE_BISHOP  4'd3
`define WHITE_ROOK    4'd4
`define WHITE_QUEEN   4'd5
`define WHITE_KING    4'd6
`define BLACK_PAWN    4'd9
`define BLACK_KNIGHT  4'd10
`define BLACK_BISHOP  4'd11
`define BLACK_ROOK    4'd12
`define BLACK_QUEEN   4'd13
`define BLACK_KING    4'd14
`define WHITE_ATTACK  1'b0
`define BLACK_ATTACK  1'b1
`endif

package attack_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t;

    localparam int KNIGHT_DR [8] = '{ 2,  2, -2, -2,  1,  1, -1, -1};
    localparam int KNIGHT_DF [8] = '{ 1, -1,  1, -1,  2, -2,  2, -2};
    localparam int KING_DR   [8] = '{ 1,  1,  1,  0,  0, -1, -1, -1};
    localparam int KING_DF   [8] = '{-1,  0,  1, -1,  1, -1,  0,  1};
    // Directions 0-3 are orthogonal (rook/queen), 4-7 diagonal (bishop/queen).
    localparam int RAY_DR    [8] = '{ 1, -1,  0,  0,  1,  1, -1, -1};
    localparam int RAY_DF    [8] = '{ 0,  0,  1, -1,  1, -1,  1, -1};

    function automatic logic sq_on_board(input int r, input int f);
        return (r >= 0) && (r < 8) && (f >= 0) && (f < 8);
    endfunction
endpackage

// File: rtl/attack_square_eval.sv
// Combinational test of whether one target square is attacked by the given side
// on a latched board (knights, king, pawns and ray-walking sliders).
module attack_square_eval
    import attack_pkg::*;
#(
    parameter int PIECE_WIDTH = 4,
    parameter int BOARD_WIDTH = 64*PIECE_WIDTH
) (
    input  logic [BOARD_WIDTH-1:0] board,
    input  logic                   attacker,
    input  logic [5:0]             square,
    output logic                   attacked
);
    logic [PIECE_WIDTH-1:0] own_pawn, own_knight, own_bishop, own_rook, own_queen, own_king;

    assign own_pawn   = attacker ? `BLACK_PAWN   : `WHITE_PAWN;
    assign own_knight = attacker ? `BLACK_KNIGHT : `WHITE_KNIGHT;
    assign own_bishop = attacker ? `BLACK_BISHOP : `WHITE_BISHOP;
    assign own_rook   = attacker ? `BLACK_ROOK   : `WHITE_ROOK;
    assign own_queen  = attacker ? `BLACK_QUEEN  : `WHITE_QUEEN;
    assign own_king   = attacker ? `BLACK_KING   : `WHITE_KING;

    // Off-board coordinates read square 0; every caller also gates on sq_on_board.
    function automatic logic [PIECE_WIDTH-1:0] piece_at(input logic [BOARD_WIDTH-1:0] b,
                                                        input int r, input int f);
        int idx;
        idx = sq_on_board(r, f) ? (r*8 + f) : 0;
        return b[idx*PIECE_WIDTH +: PIECE_WIDTH];
    endfunction

    always_comb begin
        int tr, tf, r, f, pr;
        logic path_clear;
        logic [PIECE_WIDTH-1:0] p;
        tr = int'(square[5:3]);
        tf = int'(square[2:0]);
        r = 0;
        f = 0;
        p = '0;
        path_clear = 1'b0;
        attacked = 1'b0;
        pr = attacker ? tr + 1 : tr - 1;
        for (int i = 0; i < 8; i++) begin
            r = tr + KNIGHT_DR[i];
            f = tf + KNIGHT_DF[i];
            if (sq_on_board(r, f) && piece_at(board, r, f) == own_knight) attacked = 1'b1;
            r = tr + KING_DR[i];
            f = tf + KING_DF[i];
            if (sq_on_board(r, f) && piece_at(board, r, f) == own_king) attacked = 1'b1;
        end
        for (int s = -1; s <= 1; s += 2) begin
            if (sq_on_board(pr, tf + s) && piece_at(board, pr, tf + s) == own_pawn) attacked = 1'b1;
        end
        for (int d = 0; d < 8; d++) begin
            path_clear = 1'b1;
            for (int k = 1; k < 8; k++) begin
                r = tr + RAY_DR[d]*k;
                f = tf + RAY_DF[d]*k;
                if (path_clear && sq_on_board(r, f)) begin
                    p = piece_at(board, r, f);
                    if (p != `EMPTY_POSN) begin
                        path_clear = 1'b0;
                        if (p == own_queen || p == ((d < 4) ? own_rook : own_bishop)) attacked = 1'b1;
                    end
                end else begin
                    path_clear = 1'b0;
                end
            end
        end
    end
endmodule

// File: rtl/attack_mask_scan.sv
// Sequential attack-mask scanner: latches a board and evaluates LANES squares per cycle.
// Define ATTACK_SCAN_CHECK_EN to add defender-king tracking and the in_check output.
module attack_mask_scan
    import attack_pkg::*;
#(
    parameter int PIECE_WIDTH = 4,
    parameter int ROW_WIDTH   = 8*PIECE_WIDTH,
    parameter int BOARD_WIDTH = 64*PIECE_WIDTH,
    parameter int LANES       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BOARD_WIDTH-1:0] board,
    input  logic                   attacker,
    input  logic                   board_valid,
    output logic                   board_ready,
    output logic [63:0]            attack_mask,
`ifdef ATTACK_SCAN_CHECK_EN
    output logic                   in_check,
`endif
    output logic                   attack_valid
);
    localparam int STEPS = 64 / LANES;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 ||
          LANES == 16 || LANES == 32 || LANES == 64)) begin : g_bad_lanes
        $error("attack_mask_scan: LANES must be a power of two from 1 to 64");
    end
    if (ROW_WIDTH != 8*PIECE_WIDTH || BOARD_WIDTH != 64*PIECE_WIDTH) begin : g_bad_width
        $error("attack_mask_scan: ROW_WIDTH/BOARD_WIDTH inconsistent with PIECE_WIDTH");
    end

    scan_state_t            state, state_nxt;
    logic [CNT_W-1:0]       scan_cnt;
    logic [BOARD_WIDTH-1:0] board_q;
    logic                   attacker_q;
    logic                   accept, scan_en, scan_done, scan_last;
    logic [5:0]             lane_sq [LANES];
    logic [LANES-1:0]       lane_hit;

    assign accept    = board_valid && board_ready;
    assign scan_last = (scan_cnt == CNT_W'(STEPS - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (board_valid) state_nxt = SCAN;
            SCAN:    if (scan_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        board_ready = (state == IDLE);
        scan_en     = (state == SCAN);
        scan_done   = (state == DONE);
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_sq[l] = 6'(int'(scan_cnt) * LANES + l);
        attack_square_eval #(
            .PIECE_WIDTH(PIECE_WIDTH),
            .BOARD_WIDTH(BOARD_WIDTH)
        ) u_eval (
            .board    (board_q),
            .attacker (attacker_q),
            .square   (lane_sq[l]),
            .attacked (lane_hit[l])
        );
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            board_q    <= board;
            attacker_q <= attacker;
        end
    end

    // attack_valid is registered off DONE, so it rises one edge after the last scan write.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt     <= '0;
            attack_mask  <= '0;
            attack_valid <= 1'b0;
        end else begin
            attack_valid <= scan_done;
            if (accept) begin
                scan_cnt    <= '0;
                attack_mask <= '0;
            end else if (scan_en) begin
                scan_cnt <= scan_cnt + 1'b1;
                for (int l = 0; l < LANES; l++) attack_mask[lane_sq[l]] <= lane_hit[l];
            end
        end
    end

`ifdef ATTACK_SCAN_CHECK_EN
    logic [PIECE_WIDTH-1:0] def_king;
    logic                   king_found, lane_king_hit;
    logic [5:0]             king_sq, lane_king_sq;

    assign def_king = attacker_q ? `WHITE_KING : `BLACK_KING;

    // Descending walk leaves the lowest-numbered matching lane as the winner.
    always_comb begin
        lane_king_hit = 1'b0;
        lane_king_sq  = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (board_q[int'(lane_sq[l])*PIECE_WIDTH +: PIECE_WIDTH] == def_king) begin
                lane_king_hit = 1'b1;
                lane_king_sq  = lane_sq[l];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            king_found <= 1'b0;
            king_sq    <= '0;
            in_check   <= 1'b0;
        end else begin
            if (accept) begin
                king_found <= 1'b0;
                king_sq    <= '0;
            end else if (scan_en && lane_king_hit && !king_found) begin
                king_found <= 1'b1;
                king_sq    <= lane_king_sq;
            end
            if (scan_done) in_check <= king_found && attack_mask[king_sq];
        end
    end
`endif
endmodule
